// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: FIFO of retired-instruction records with sticky overflow/halt/drained status.
// Define RETIRE_TRACE_CNT_EN to include the 32-bit retire and drop statistics counters.
module retire_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_retire_valid,
  input  logic [31:0]            i_retire_pc,
  input  logic [31:0]            i_retire_inst,
  input  logic [31:0]            i_retire_rd_wdata,
  input  logic [4:0]             i_retire_rd_waddr,
  input  logic                   i_retire_trap,
  input  logic                   i_retire_halt,
  output logic                   o_trace_valid,
  input  logic                   i_trace_ready,
  output logic [31:0]            o_trace_pc,
  output logic [31:0]            o_trace_inst,
  output logic [31:0]            o_trace_rd_wdata,
  output logic [4:0]             o_trace_rd_waddr,
  output logic                   o_trace_trap,
  output logic                   o_trace_halt,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  output logic                   o_halted,
  output logic                   o_drained,
  output logic [31:0]            o_retire_cnt,
  output logic [31:0]            o_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  logic [102:0]  r_mem [DEPTH];
  logic [102:0]  w_wr;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level;
  logic          r_overflow, r_halted, w_push, w_pop, w_drop;
  assign w_pop  = (r_level != '0) && i_trace_ready;
  assign w_push = i_retire_valid && !r_halted && (r_level < L_FULL || w_pop);
  // once halted, later retires vanish silently rather than counting as drops
  assign w_drop = i_retire_valid && !r_halted && !w_push;
  assign w_wr   = {i_retire_pc, i_retire_inst, i_retire_rd_wdata, i_retire_rd_waddr, i_retire_trap, i_retire_halt};
  assign {o_trace_pc, o_trace_inst, o_trace_rd_wdata, o_trace_rd_waddr, o_trace_trap, o_trace_halt} = r_mem[r_rp];
  assign o_trace_valid = r_level != '0;
  assign o_level       = r_level;
  assign o_overflow    = r_overflow;
  assign o_halted      = r_halted;
  assign o_drained     = r_halted && (r_level == '0);
  always_ff @(posedge i_clk)
    if (w_push && !i_rst) r_mem[r_wp] <= w_wr;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
      if (w_push && i_retire_halt) r_halted <= 1'b1;
    end
`ifdef RETIRE_TRACE_CNT_EN
  logic [31:0] r_retire_cnt, r_drop_cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_retire_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_push) r_retire_cnt <= r_retire_cnt + 32'd1;
      if (w_drop) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  assign o_retire_cnt = r_retire_cnt;
  assign o_drop_cnt   = r_drop_cnt;
`else
  assign o_retire_cnt = 32'd0;
  assign o_drop_cnt   = 32'd0;
`endif
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: directed stimulus with a queue scoreboard; a negedge monitor checks every popped record.
module tb_retire_trace_buffer;
`ifdef RETIRE_TRACE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] pc, inst, wdata;
    logic [4:0]  waddr;
    logic        trap, halt;
  } rec_t;
  logic clk = 1'b0, rst = 1'b1, rv = 1'b0, rdy = 1'b0;
  rec_t in_r = '0, out_r, e;
  logic tv, ovf, halted, drained;
  logic [3:0] level;
  logic [31:0] rcnt, dcnt;
  rec_t exp_q[$];
  int tests = 0, fails = 0;

  retire_trace_buffer #(.DEPTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_retire_valid(rv),
    .i_retire_pc(in_r.pc), .i_retire_inst(in_r.inst), .i_retire_rd_wdata(in_r.wdata),
    .i_retire_rd_waddr(in_r.waddr), .i_retire_trap(in_r.trap), .i_retire_halt(in_r.halt),
    .o_trace_valid(tv), .i_trace_ready(rdy),
    .o_trace_pc(out_r.pc), .o_trace_inst(out_r.inst), .o_trace_rd_wdata(out_r.wdata),
    .o_trace_rd_waddr(out_r.waddr), .o_trace_trap(out_r.trap), .o_trace_halt(out_r.halt),
    .o_level(level), .o_overflow(ovf), .o_halted(halted), .o_drained(drained),
    .o_retire_cnt(rcnt), .o_drop_cnt(dcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic halt);
    rec_t r;
    r.pc = pc; r.inst = inst; r.wdata = wdata; r.waddr = rd; r.trap = pc[3]; r.halt = halt;
    return r;
  endfunction

  // inputs change 1 time unit after posedge and act on the following posedge
  task automatic step(input logic v, input rec_t r, input logic ready, input bit acc);
    @(posedge clk); #1;
    rv = v; in_r = r; rdy = ready;
    if (v && acc) exp_q.push_back(r);
  endtask

  task automatic idle(input logic ready);
    step(1'b0, '0, ready, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rv = 1'b0; rdy = 1'b0; rst = 1'b1;
    exp_q.delete();
    #2 rst = 1'b0;
  endtask

  // the record presented while ready is high is consumed on the next posedge
  always @(negedge clk)
    if (!rst && tv && rdy) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: got pc %0h expected no record", out_r.pc);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_r.pc, e.pc);
        check("out_inst", out_r.inst, e.inst);
        check("out_wdata", out_r.wdata, e.wdata);
        check("out_misc", 32'({out_r.waddr, out_r.trap, out_r.halt}), 32'({e.waddr, e.trap, e.halt}));
      end
    end

  initial begin
    #2;
    check("rst_valid", 32'(tv), 0);
    check("rst_level", 32'(level), 0);
    check("rst_flags", 32'({ovf, halted, drained}), 0);
    check("rst_cnts", rcnt | dcnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single pass
    step(1'b1, mk(32'h0, 32'h0050_0093, 32'd5, 5'd1, 1'b0), 1'b1, 1'b1);
    idle(1'b1);
    check("single_level1", 32'(level), 1);
    check("single_valid1", 32'(tv), 1);
    idle(1'b1);
    check("single_level0", 32'(level), 0);
    check("single_valid0", 32'(tv), 0);
    check("single_q", exp_q.size(), 0);

    // fill and overflow
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, mk(32'h100 + 4*i, 32'h13 + i, i, 5'(i + 2), 1'b0), 1'b0, i < 8);
    idle(1'b0);
    check("fill_level", 32'(level), 8);
    check("fill_ovf", 32'(ovf), 1);
    check("fill_drop_cnt", dcnt, CNT_EN ? 32'd2 : 32'd0);
    check("fill_ret_cnt", rcnt, CNT_EN ? 32'd8 : 32'd0);
    check("fill_head", out_r.pc, 32'h100);
    idle(1'b0);
    check("fill_head_hold", out_r.pc, 32'h100);

    // full with concurrent pop
    for (int i = 0; i < 5; i++) step(1'b1, mk(32'h200 + 4*i, 32'h33 + i, 32'hA0 + i, 5'd7, 1'b0), 1'b1, 1'b1);
    idle(1'b0);
    check("fullpop_level", 32'(level), 8);
    check("fullpop_drop_cnt", dcnt, CNT_EN ? 32'd2 : 32'd0);
    check("fullpop_ret_cnt", rcnt, CNT_EN ? 32'd13 : 32'd0);
    for (int i = 0; i < 9; i++) idle(1'b1);
    check("fullpop_drain_level", 32'(level), 0);
    check("fullpop_q", exp_q.size(), 0);

    // halt
    do_reset();
    step(1'b1, mk(32'h10, 32'h1, 32'h11, 5'd3, 1'b0), 1'b0, 1'b1);
    step(1'b1, mk(32'h20, 32'h0010_0073, 32'h22, 5'd0, 1'b1), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, mk(32'h24 + 4*i, 32'h2, 32'h33, 5'd4, 1'b0), 1'b0, 1'b0);
    idle(1'b0);
    check("halt_halted", 32'(halted), 1);
    check("halt_ovf", 32'(ovf), 0);
    check("halt_level", 32'(level), 2);
    check("halt_drained_early", 32'(drained), 0);
    check("halt_drop_cnt", dcnt, 0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("halt_drained", 32'(drained), 1);
    check("halt_q", exp_q.size(), 0);

    // halt record arriving while full is an ordinary drop
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, mk(32'h300 + 4*i, 32'h5, 32'h6, 5'd9, 1'b0), 1'b0, 1'b1);
    step(1'b1, mk(32'h320, 32'h0010_0073, 32'h0, 5'd0, 1'b1), 1'b0, 1'b0);
    idle(1'b0);
    check("fullhalt_halted", 32'(halted), 0);
    check("fullhalt_ovf", 32'(ovf), 1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    check("fullhalt_q", exp_q.size(), 0);

    // mid-operation reset
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, mk(32'h400 + 4*i, 32'h7, 32'h8, 5'd10, 1'b0), 1'b0, 1'b1);
    idle(1'b0);
    check("midrst_pre_level", 32'(level), 5);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(tv), 0);
    check("midrst_level", 32'(level), 0);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("midrst_post_level", 32'(level), 0);

    // wrap-around
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, mk(32'h1000 + 4*i, 32'h9000 + i, 32'h50 + i, 5'(i), 1'b0), 1'b1, 1'b1);
      idle(1'(i % 2));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("wrap_q", exp_q.size(), 0);
    check("wrap_ovf", 32'(ovf), 0);
    check("wrap_ret_cnt", rcnt, CNT_EN ? 32'd20 : 32'd0);
    check("wrap_level", 32'(level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
